// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if
//   Bundles the pipeline-side signals of the hazard/stall controller.
//   master : pipeline side (drives the hazard inputs, receives the stall controls)
//   slave  : controller side
//   Signals:
//     id_ex_memread, id_ex_regwrite, id_ex_dst   EX-stage instruction info
//     ex_mem_memread, ex_mem_dst                 MEM-stage instruction info
//     if_id_rs, if_id_rt, if_id_use_rs/rt        ID-stage sources and usage
//     if_id_branch, branch_taken                 ID-stage branch info
//     pc_write, if_id_write, mux_sel             stall controls
//     if_id_flush                                IF/ID flush for taken branches
//     stall_cycles                               saturating stalled-cycle count
interface hazard_stall_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_ex_memread;
    logic             id_ex_regwrite;
    logic [REG_W-1:0] id_ex_dst;
    logic             ex_mem_memread;
    logic [REG_W-1:0] ex_mem_dst;
    logic [REG_W-1:0] if_id_rs;
    logic [REG_W-1:0] if_id_rt;
    logic             if_id_use_rs;
    logic             if_id_use_rt;
    logic             if_id_branch;
    logic             branch_taken;
    logic             pc_write;
    logic             if_id_write;
    logic             mux_sel;
    logic             if_id_flush;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_ex_memread, id_ex_regwrite, id_ex_dst,
        output ex_mem_memread, ex_mem_dst,
        output if_id_rs, if_id_rt, if_id_use_rs, if_id_use_rt,
        output if_id_branch, branch_taken,
        input  pc_write, if_id_write, mux_sel, if_id_flush, stall_cycles
    );

    modport slave (
        input  id_ex_memread, id_ex_regwrite, id_ex_dst,
        input  ex_mem_memread, ex_mem_dst,
        input  if_id_rs, if_id_rt, if_id_use_rs, if_id_use_rt,
        input  if_id_branch, branch_taken,
        output pc_write, if_id_write, mux_sel, if_id_flush, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Load-use / branch hazard controller beside the ID stage. Detects hazards
//   combinationally, holds multi-cycle load stalls with a down-counter FSM,
//   and keeps a saturating count of stalled cycles.
//   Ports:
//     clk  : pipeline clock, rising edge
//     rst  : asynchronous active-high reset (also forces non-stall outputs)
//     bus  : hazard_stall_ctrl_if.slave (hazard inputs, stall/flush outputs)
//   Parameters: REG_W register-address width, LOAD_STALL cycles per load-use
//   stall (1..7), CNT_W width of stall_cycles.
//   Build option: define BRANCH_HAZARD_EN to compile in branch hazards and
//   the IF/ID flush; without it only load-use stalls occur and flush is 0.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | comparators live; stall only on a same-cycle hazard
//   HOLD  | extending a load-use stall; comparators ignored, cnt counts down
module hazard_stall_ctrl #(
    parameter int REG_W      = 5,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input logic               clk,
    input logic               rst,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       load_hz;
    logic       br_hz;
    logic       flush_raw;
    logic       stall;

    function automatic logic match_x(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic             use_rs,
                                     input logic             use_rt);
        return (dst != '0) && ((use_rs && (dst == rs)) || (use_rt && (dst == rt)));
    endfunction

    assign load_hz = bus.id_ex_memread &&
                     match_x(bus.id_ex_dst, bus.if_id_rs, bus.if_id_rt,
                             bus.if_id_use_rs, bus.if_id_use_rt);

`ifdef BRANCH_HAZARD_EN
    assign br_hz = bus.if_id_branch &&
                   ((bus.id_ex_regwrite &&
                     match_x(bus.id_ex_dst, bus.if_id_rs, bus.if_id_rt,
                             bus.if_id_use_rs, bus.if_id_use_rt)) ||
                    (bus.ex_mem_memread &&
                     match_x(bus.ex_mem_dst, bus.if_id_rs, bus.if_id_rt,
                             bus.if_id_use_rs, bus.if_id_use_rt)));
    assign flush_raw = bus.branch_taken && bus.if_id_branch && !stall;
`else
    logic unused_branch_inputs;
    assign unused_branch_inputs = ^{bus.id_ex_regwrite, bus.ex_mem_memread,
                                    bus.ex_mem_dst, bus.if_id_branch,
                                    bus.branch_taken};
    assign br_hz     = 1'b0;
    assign flush_raw = 1'b0;
`endif

    assign stall = (state == HOLD) || load_hz || br_hz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Entry cycle is itself a stall cycle, so HOLD only covers LOAD_STALL-1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (load_hz && (LOAD_STALL > 1)) begin
                    state_nxt = HOLD;
                    cnt_nxt   = 3'(LOAD_STALL - 1);
                end
            end
            HOLD: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are overridden while rst is high so the pipeline runs freely.
    assign bus.pc_write    = rst || !stall;
    assign bus.if_id_write = rst || !stall;
    assign bus.mux_sel     = !rst && stall;
    assign bus.if_id_flush = !rst && flush_raw;

    logic [CNT_W-1:0] stall_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    assign bus.stall_cycles = stall_cycles;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
//   Three controllers share one directed input stream:
//     a : LOAD_STALL=1, CNT_W=16
//     b : LOAD_STALL=3, CNT_W=16
//     c : LOAD_STALL=4, CNT_W=4 (saturation)
//   Each vector pushes hand-computed expectations into a queue; a monitor
//   samples the outputs each cycle and pops/compares.
module tb_hazard_stall_ctrl;
`ifdef BRANCH_HAZARD_EN
    localparam int M = 1;
`else
    localparam int M = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(16)) if_a ();
    hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(16)) if_b ();
    hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(4))  if_c ();

    hazard_stall_ctrl #(.REG_W(5), .LOAD_STALL(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave));
    hazard_stall_ctrl #(.REG_W(5), .LOAD_STALL(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave));
    hazard_stall_ctrl #(.REG_W(5), .LOAD_STALL(4), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c.slave));

    typedef struct {
        int         vec;
        logic [2:0] stall;   // bit0=a, bit1=b, bit2=c
        logic [2:0] flush;
        int         cnt_a;
        int         cnt_b;
        int         cnt_c;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   vec_id = 0;

    task automatic chk(input string name, input int vec, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s vec=%0d actual=%0d required=%0d", name, vec, act, req);
        end
    endtask

    task automatic drive_if(input int which,
                            input logic mr, input logic rw, input int idst,
                            input logic emr, input int edst,
                            input int rs, input int rt, input logic urs, input logic urt,
                            input logic br, input logic tk);
        case (which)
            0: begin
                if_a.id_ex_memread = mr;  if_a.id_ex_regwrite = rw; if_a.id_ex_dst = 5'(idst);
                if_a.ex_mem_memread = emr; if_a.ex_mem_dst = 5'(edst);
                if_a.if_id_rs = 5'(rs); if_a.if_id_rt = 5'(rt);
                if_a.if_id_use_rs = urs; if_a.if_id_use_rt = urt;
                if_a.if_id_branch = br; if_a.branch_taken = tk;
            end
            1: begin
                if_b.id_ex_memread = mr;  if_b.id_ex_regwrite = rw; if_b.id_ex_dst = 5'(idst);
                if_b.ex_mem_memread = emr; if_b.ex_mem_dst = 5'(edst);
                if_b.if_id_rs = 5'(rs); if_b.if_id_rt = 5'(rt);
                if_b.if_id_use_rs = urs; if_b.if_id_use_rt = urt;
                if_b.if_id_branch = br; if_b.branch_taken = tk;
            end
            default: begin
                if_c.id_ex_memread = mr;  if_c.id_ex_regwrite = rw; if_c.id_ex_dst = 5'(idst);
                if_c.ex_mem_memread = emr; if_c.ex_mem_dst = 5'(edst);
                if_c.if_id_rs = 5'(rs); if_c.if_id_rt = 5'(rt);
                if_c.if_id_use_rs = urs; if_c.if_id_use_rt = urt;
                if_c.if_id_branch = br; if_c.branch_taken = tk;
            end
        endcase
    endtask

    // One cycle: drive at negedge, queue what the monitor must see this cycle.
    task automatic step(input logic r, input logic mr, input logic rw, input int idst,
                        input logic emr, input int edst,
                        input int rs, input int rt, input logic urs, input logic urt,
                        input logic br, input logic tk,
                        input logic [2:0] s, input logic [2:0] f,
                        input int ca, input int cb, input int cc);
        exp_t e;
        @(negedge clk);
        rst = r;
        for (int i = 0; i < 3; i++) drive_if(i, mr, rw, idst, emr, edst, rs, rt, urs, urt, br, tk);
        e.vec = vec_id; e.stall = s; e.flush = f;
        e.cnt_a = ca; e.cnt_b = cb; e.cnt_c = cc;
        exp_q.push_back(e);
        vec_id++;
    endtask

    task automatic idle(input logic [2:0] s, input int ca, input int cb, input int cc);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, s, 3'b000, ca, cb, cc);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("a_pc_write",    e.vec, int'(if_a.pc_write),    int'(!e.stall[0]));
                chk("a_if_id_write", e.vec, int'(if_a.if_id_write), int'(!e.stall[0]));
                chk("a_mux_sel",     e.vec, int'(if_a.mux_sel),     int'(e.stall[0]));
                chk("a_flush",       e.vec, int'(if_a.if_id_flush), int'(e.flush[0]));
                chk("a_stall_cycles", e.vec, int'(if_a.stall_cycles), e.cnt_a);
                chk("b_pc_write",    e.vec, int'(if_b.pc_write),    int'(!e.stall[1]));
                chk("b_if_id_write", e.vec, int'(if_b.if_id_write), int'(!e.stall[1]));
                chk("b_mux_sel",     e.vec, int'(if_b.mux_sel),     int'(e.stall[1]));
                chk("b_flush",       e.vec, int'(if_b.if_id_flush), int'(e.flush[1]));
                chk("b_stall_cycles", e.vec, int'(if_b.stall_cycles), e.cnt_b);
                chk("c_pc_write",    e.vec, int'(if_c.pc_write),    int'(!e.stall[2]));
                chk("c_if_id_write", e.vec, int'(if_c.if_id_write), int'(!e.stall[2]));
                chk("c_mux_sel",     e.vec, int'(if_c.mux_sel),     int'(e.stall[2]));
                chk("c_flush",       e.vec, int'(if_c.if_id_flush), int'(e.flush[2]));
                chk("c_stall_cycles", e.vec, int'(if_c.stall_cycles), e.cnt_c);
            end
        end
    end

    // Stimulus
    initial begin
        logic [2:0] fm;
        int drain;
        fm = (M != 0) ? 3'b111 : 3'b000;
        for (int i = 0; i < 3; i++) drive_if(i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset, then idle
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0);
        idle(3'b000, 0, 0, 0);
        // load r5 in EX, ID reads rs=r5; then EX bubble while ID is held
        step(0, 1, 1, 5, 0, 0, 5, 0, 1, 0, 0, 0, 3'b111, 3'b000, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 3'b110, 3'b000, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 3'b110, 3'b000, 1, 2, 2);
        step(0, 0, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 3'b100, 3'b000, 1, 3, 3);
        step(0, 0, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 3'b000, 3'b000, 1, 3, 4);
        // x0 never hazards; unused rt never hazards
        step(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3'b000, 3'b000, 1, 3, 4);
        step(0, 1, 1, 7, 0, 0, 3, 7, 1, 0, 0, 0, 3'b000, 3'b000, 1, 3, 4);
        // rt match with use_rt, then reset in the middle of HOLD
        step(0, 1, 1, 7, 0, 0, 3, 7, 1, 1, 0, 0, 3'b111, 3'b000, 1, 3, 4);
        step(0, 0, 0, 0, 0, 0, 3, 7, 1, 1, 0, 0, 3'b110, 3'b000, 2, 4, 5);
        step(1, 0, 0, 0, 0, 0, 3, 7, 1, 1, 0, 0, 3'b000, 3'b000, 0, 0, 0);
        idle(3'b000, 0, 0, 0);
        // 20 back-to-back hazard cycles: c saturates at 15
        for (int k = 0; k < 20; k++)
            step(0, 1, 1, 5, 0, 0, 5, 0, 1, 0, 0, 0, 3'b111, 3'b000,
                 k, k, (k > 15) ? 15 : k);
        idle(3'b010, 20, 20, 15);
        idle(3'b000, 20, 21, 15);
        // ALU writes r8 in EX, branch on r8 (taken) in ID
        step(0, 0, 1, 8, 0, 0, 8, 0, 1, 0, 1, 1, fm, 3'b000, 20, 21, 15);
        step(0, 0, 0, 0, 0, 8, 8, 0, 1, 0, 1, 1, 3'b000, fm, 20 + M, 21 + M, 15);
        idle(3'b000, 20 + M, 21 + M, 15);
        // load r9, then branch on r9 (taken)
        step(0, 1, 1, 9, 0, 0, 9, 0, 1, 0, 1, 1, 3'b111, 3'b000, 20 + M, 21 + M, 15);
        step(0, 0, 0, 0, 1, 9, 9, 0, 1, 0, 1, 1, {2'b11, 1'(M)}, 3'b000, 21 + M, 22 + M, 15);
        step(0, 0, 0, 0, 0, 0, 9, 0, 1, 0, 1, 1, 3'b110, {2'b00, 1'(M)}, 21 + 2*M, 23 + M, 15);
        idle(3'b100, 21 + 2*M, 24 + M, 15);
        idle(3'b000, 21 + 2*M, 24 + M, 15);

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        @(negedge clk);
        #4;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d required=0 pending", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
